byte_serial_add_ctrl: RTL and testbench

Sequencer that performs wide (8*NBYTES-bit) add/subtract by time-multiplexing one 8-bit ripple-carry adder instance, one byte per clock, LSB byte first. It holds a registered carry between bytes and handles operand latching, byte selection, result assembly and the start/done handshake. It sits between the ALU control logic and the shared 8-bit rca datapath.

---
 rtl/byte_serial_add_defs_pkg.sv | 29 ++
 rtl/byte_serial_add_ctrl_rca.sv | 31 +++
 rtl/byte_serial_add_ctrl.sv | 127 ++++++++++++
 tb/tb_byte_serial_add_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_serial_add_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add_defs_pkg
//  Description : Shared definitions for the byte-serial add/subtract
//                sequencer: FSM state encoding, default slice count and
//                a constant ceil(log2) helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_serial_add_defs_pkg;

    // FSM state encoding
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Default number of byte slices per operand
    localparam int NBYTES_DEFAULT = 4;

    // Ceiling log2 for sizing the byte index (value >= 2)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_serial_add_ctrl_rca.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add_ctrl_rca
//  Description : Plain 8-bit ripple-carry adder; the shared datapath slice
//                that the sequencer time-multiplexes across operand bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_add_ctrl_rca (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [8:0] w_c;

    assign w_c[0] = i_cin;

    // One full adder per bit, carry rippling from bit 0 upward
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate

    assign o_cout = w_c[8];

endmodule
`default_nettype wire

// File: rtl/byte_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_serial_add_ctrl
//  Description : Wide (8*NBYTES-bit) add/subtract sequencer. One shared
//                8-bit ripple-carry adder processes a byte per clock, LSB
//                byte first, with the carry registered between bytes.
//                Optional macro BYTE_SERIAL_ADD_ACC_EN adds an 'acc' input
//                that feeds the previous result back as operand A.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_add_ctrl
    import byte_serial_add_defs_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
`ifdef BYTE_SERIAL_ADD_ACC_EN
    input  logic                acc,
`endif
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                overflow
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = clog2(NBYTES);
    localparam logic [IDXW-1:0] c_last_idx = IDXW'(NBYTES - 1);

    logic [0:0]      r_state;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_opa;
    logic [W-1:0]    r_opb;
    logic            r_carry;
    logic [W-1:0]    r_result;
    logic            r_busy;
    logic            r_done;
    logic            r_cout;
    logic            r_ovf;

    logic [IDXW+2:0] w_base;
    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_sum;
    logic            w_cout;
    logic [W-1:0]    w_opa_src;
    logic            w_last;

    // Bit offset of the byte currently being processed
    assign w_base   = {r_idx, 3'b000};
    assign w_a_byte = r_opa[w_base +: 8];
    assign w_b_byte = r_opb[w_base +: 8];
    assign w_last   = (r_idx == c_last_idx);

`ifdef BYTE_SERIAL_ADD_ACC_EN
    // Accumulate mode reuses the held result as operand A
    assign w_opa_src = acc ? r_result : a;
`else
    assign w_opa_src = a;
`endif

    byte_serial_add_ctrl_rca u_rca (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // FSM, operand latching, byte write-back and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B here, carry-in 1
                    r_opa    <= w_opa_src;
                    r_opb    <= sub ? ~b : b;
                    r_carry  <= sub;
                    r_idx    <= '0;
                    r_busy   <= 1'b1;
                    r_result <= '0;
                    r_state  <= S_RUN;
                end
            end else begin
                r_result[w_base +: 8] <= w_sum;
                r_carry               <= w_cout;
                if (w_last) begin
                    // Signed overflow: equal-sign inputs yielding a sign flip
                    r_cout  <= w_cout;
                    r_ovf   <= (r_opa[W-1] == r_opb[W-1]) && (w_sum[7] != r_opa[W-1]);
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end else begin
                    r_idx <= r_idx + IDXW'(1);
                end
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_byte_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_serial_add_ctrl
//  Description : Directed self-checking bench for byte_serial_add_ctrl
//                (NBYTES=4) with a scoreboard of expected results.
//                Honours BYTE_SERIAL_ADD_ACC_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_add_ctrl;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic         acc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    exp_t         sb[$];
    logic [W-1:0] model_res;
    int           n_checks;
    int           n_fail;

    byte_serial_add_ctrl #(
        .NBYTES (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
`ifdef BYTE_SERIAL_ADD_ACC_EN
        .acc      (acc),
`endif
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive request, compute reference, return at the
    // negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input logic tacc);
        exp_t         e;
        logic [W-1:0] base;
        logic [W:0]   s33;
        base  = tacc ? model_res : ta;
        s33   = {1'b0, base} + {1'b0, tb_};
        e.res = ts ? (base - tb_) : (base + tb_);
        e.co  = ts ? (base >= tb_) : s33[W];
        e.ov  = ts ? ((base[W-1] != tb_[W-1]) && (e.res[W-1] != base[W-1]))
                   : ((base[W-1] == tb_[W-1]) && (e.res[W-1] != base[W-1]));
        model_res = e.res;
        sb.push_back(e);
        a     = ta;
        b     = tb_;
        sub   = ts;
        acc   = tacc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; lat counts edges since the accepting edge
    task automatic wait_done(input int n0, output int lat, output int bcnt);
        lat  = n0;
        bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.co});
            check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ov});
        end
    endtask

    task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts, input logic tacc);
        int           lat;
        int           bcnt;
        logic [W-1:0] held;
        issue(ta, tb_, ts, tacc);
        a = $urandom;
        b = $urandom;
        sub = ~ts;
        wait_done(0, lat, bcnt);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd4);
        check_out(tag);
        held = result;
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, result, held);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_res = '0;
    endtask

    initial begin
        int lat;
        int bcnt;
        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        sub       = 1'b0;
        acc       = 1'b0;
        a         = '0;
        b         = '0;
        model_res = '0;
        rst       = 1'b1;
        @(negedge clk);
        do_reset();

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);

        op("add_ff_1",     32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        op("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        op("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        op("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        op("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        op("add_mixed",    32'h1234_5678, 32'h89AB_CDEF, 1'b0, 1'b0);

        // Start while busy is ignored
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        @(negedge clk);
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(2, lat, bcnt);
        check("ignore_latency", 32'(lat), 32'd4);
        check_out("ignore");
        @(negedge clk);
        check("ignore_no_second", {31'd0, busy}, 32'd0);

        // Start in the done cycle is accepted
        issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        wait_done(0, lat, bcnt);
        check("b2b_first_latency", 32'(lat), 32'd4);
        check_out("b2b_first");
        issue(32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0);
        wait_done(0, lat, bcnt);
        check("b2b_second_latency", 32'(lat), 32'd4);
        check_out("b2b_second");
        @(negedge clk);

        // Reset in the second RUN cycle discards the operation
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        model_res = '0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", result, 32'd0);
        op("after_rst", 32'h0001_0000, 32'h0000_FFFF, 1'b0, 1'b0);

`ifdef BYTE_SERIAL_ADD_ACC_EN
        do_reset();
        op("acc_first",  32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b1);
        op("acc_second", 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 1'b1);
        op("acc_sub",    32'h0000_0000, 32'h0000_0005, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
